prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
- REQ-001 Parameter AW, default 8, start-PC width.
- REQ-002 Parameter CW, default 16, cycle-counter width.
- REQ-003 Parameter TIMEOUT, default 16'd50000, max cycles per program before abort.
- REQ-004 clk  input  1  single system clock, all state on rising edge.
- REQ-005 reset_n  input  1  asynchronous, active-low reset.
- REQ-006 req  input  1  start request, sampled each cycle when idle.
- REQ-007 prog_sel  input  2  0/1/2 = run program 1/2/3 only; 3 = run all three in order.
- REQ-008 core_init  output  1  one-cycle launch pulse to CPU core.
- REQ-009 core_pc  output  AW  start PC presented to core; valid while core_init high.
- REQ-010 core_done  input  1  core completion level.
- REQ-011 busy  output  1  high from accepted req until ack cycle inclusive.
- REQ-012 ack  output  1  one-cycle pulse: sequence finished or aborted.
- REQ-013 prog_id  output  2  program currently or last run (0..2).
- REQ-014 cyc_count  output  CW  cycle count of last completed or aborted program.
- REQ-015 timeout  output  1  sticky abort flag.

Function
- REQ-016 The FSM SHALL have states IDLE, LAUNCH, RUN, NEXT, FIN.
- REQ-017 In IDLE, req=1 SHALL latch prog_sel, set prog_id to (prog_sel==3 ? 0 : prog_sel), clear timeout, and go to LAUNCH next cycle.
- REQ-018 req while not IDLE SHALL be ignored, with no queuing.
- REQ-019 LAUNCH SHALL assert core_init for exactly one cycle with core_pc = PC table[prog_id], clear the running counter, then go to RUN.
- REQ-020 RUN SHALL increment the running counter each cycle, saturating at all-ones.
- REQ-021 Completion SHALL be a core_done rising edge, detected with a registered previous value, seen in RUN; a level held high from a prior program SHALL NOT complete.
- REQ-022 On completion, cyc_count SHALL be loaded with the running counter and the FSM SHALL go to NEXT.
- REQ-023 If the running counter reaches TIMEOUT in RUN before completion, timeout SHALL be set, cyc_count loaded, and the FSM SHALL go to FIN, skipping remaining programs.
- REQ-024 If completion and timeout occur in the same cycle, completion SHALL win.
- REQ-025 NEXT: if latched sel==3 and prog_id<2, prog_id SHALL increment and the FSM SHALL go to LAUNCH; otherwise it SHALL go to FIN.
- REQ-026 FIN SHALL pulse ack one cycle, then return to IDLE; busy SHALL fall the cycle after FIN.
- REQ-027 Latency SHALL be: req to core_init = 2 cycles; done edge to ack = 3 cycles (single program); done edge to next core_init = 3 cycles (sel 3).
- REQ-028 All outputs SHALL be registered.

Reset
- REQ-029 reset_n low SHALL asynchronously force IDLE, core_init=0, core_pc=0, busy=0, ack=0, prog_id=0, cyc_count=0, timeout=0, running counter=0, and previous core_done=0.
- REQ-030 Reset mid-sequence SHALL abort without emitting ack.
- REQ-031 After reset_n rises, the first req SHALL be honoured normally.

Structure
- REQ-032 Package prog_seq_pkg SHALL hold the state enum, PC table constants PC_P1=8'd0, PC_P2=8'd64, PC_P3=8'd128, and the prog_sel encoding RUN_ALL=2'd3.
- REQ-033 One sub-module, edge_det (registered rising-edge detector on core_done), SHALL be used; everything else SHALL be flat.

Verification
- REQ-034 reset, req with prog_sel=1, core_done rise 20 cycles after core_init -> core_init at req+2 with core_pc=64, ack at edge+3, cyc_count=20, prog_id=1, timeout=0.
- REQ-035 prog_sel=3, core model done 10/15/12 cycles after each init -> three core_init pulses with PCs 0, 64, 128, single ack, prog_id=2, cyc_count=12.
- REQ-036 TIMEOUT=100, prog_sel=3, core never completes -> timeout=1, one core_init only, ack at init+~101, cyc_count=100, busy low after.
- REQ-037 core_done held high across launch, then low, then rises 5 cycles later -> only the later edge completes; req pulsed during RUN -> no extra core_init.
- REQ-038 reset_n low 30 cycles into RUN -> all outputs zero immediately, no ack; new req with prog_sel=0 -> core_pc=0 launch at req+2.
- REQ-039 completion edge on the cycle the counter hits TIMEOUT -> timeout=0, normal ack.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer.
package prog_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_NEXT,
    ST_FIN
  } state_t;

  // Start PC of each program in the core's instruction memory
  localparam logic [7:0] PC_P1 = 8'd0;
  localparam logic [7:0] PC_P2 = 8'd64;
  localparam logic [7:0] PC_P3 = 8'd128;

  // prog_sel value that chains all three programs
  localparam logic [1:0] RUN_ALL = 2'd3;

  // Map a program index (0..2) to its start PC
  function automatic logic [7:0] pc_of(input logic [1:0] id);
    case (id)
      2'd1:    return PC_P2;
      2'd2:    return PC_P3;
      default: return PC_P1;
    endcase
  endfunction

endpackage

// File: rtl/prog_sequencer_edge_det.sv
// Rising-edge detector: the previous level is registered, and the rise
// output is combinational against it so completion is seen the same cycle.
module edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  // Track the previous sample every cycle so a held level never re-fires
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_prev <= 1'b0;
    else          r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/prog_sequencer.sv
// Launches one or all three core programs in order, times each run,
// and aborts the whole sequence if a program exceeds TIMEOUT cycles.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int             AW      = 8,
  parameter int             CW      = 16,
  parameter logic [CW-1:0]  TIMEOUT = 16'd50000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  input  logic [1:0]    prog_sel,
  output logic          core_init,
  output logic [AW-1:0] core_pc,
  input  logic          core_done,
  output logic          busy,
  output logic          ack,
  output logic [1:0]    prog_id,
  output logic [CW-1:0] cyc_count,
  output logic          timeout
);

  state_t        r_state, w_next;
  logic [1:0]    r_sel;
  logic [1:0]    r_prog_id;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_cyc;
  logic          r_init, r_busy, r_ack, r_tmo;
  logic [AW-1:0] r_pc;

  logic w_rise, w_accept, w_done, w_hit, w_chain;

  edge_det u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (core_done),
    .o_rise  (w_rise)
  );

  assign w_accept = (r_state == ST_IDLE) & req;
  assign w_done   = (r_state == ST_RUN) & w_rise;
  // Completion beats timeout when both land in the same cycle
  assign w_hit    = (r_state == ST_RUN) & ~w_rise & (r_cnt == TIMEOUT);
  assign w_chain  = (r_sel == RUN_ALL) & (r_prog_id < 2'd2);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (req) w_next = ST_LAUNCH;
      ST_LAUNCH: w_next = ST_RUN;
      ST_RUN:    if (w_done)     w_next = ST_NEXT;
                 else if (w_hit) w_next = ST_FIN;
      ST_NEXT:   w_next = w_chain ? ST_LAUNCH : ST_FIN;
      ST_FIN:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel     <= '0;
      r_prog_id <= '0;
      r_cnt     <= '0;
      r_cyc     <= '0;
      r_init    <= 1'b0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
      r_tmo     <= 1'b0;
      r_pc      <= '0;
    end else begin
      r_init <= (r_state == ST_LAUNCH);
      r_ack  <= (r_state == ST_FIN);
      // Busy covers the ack cycle: FIN is still non-idle one edge earlier
      r_busy <= (r_state != ST_IDLE) | w_accept;

      if (w_accept) begin
        r_sel     <= prog_sel;
        r_prog_id <= (prog_sel == RUN_ALL) ? 2'd0 : prog_sel;
        r_tmo     <= 1'b0;
      end

      if (r_state == ST_LAUNCH) begin
        r_pc  <= AW'(pc_of(r_prog_id));
        r_cnt <= '0;
      end else if (r_state == ST_RUN && r_cnt != '1) begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_done) r_cyc <= r_cnt;
      if (w_hit) begin
        r_cyc <= r_cnt;
        r_tmo <= 1'b1;
      end

      if (r_state == ST_NEXT && w_chain) r_prog_id <= r_prog_id + 2'd1;
    end
  end

  assign core_init = r_init;
  assign core_pc   = r_pc;
  assign busy      = r_busy;
  assign ack       = r_ack;
  assign prog_id   = r_prog_id;
  assign cyc_count = r_cyc;
  assign timeout   = r_tmo;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer (TIMEOUT shortened to 100).
module tb_prog_sequencer;

  localparam int AW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req = 1'b0;
  logic [1:0]    prog_sel = 2'd0;
  logic          core_done = 1'b0;
  logic          core_init, busy, ack, timeout;
  logic [AW-1:0] core_pc;
  logic [1:0]    prog_id;
  logic [CW-1:0] cyc_count;

  int n_chk = 0;
  int n_err = 0;
  int n_init = 0;
  int n_ack = 0;
  int b_init, b_ack;

  prog_sequencer #(.AW(AW), .CW(CW), .TIMEOUT(16'd100)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .prog_sel  (prog_sel),
    .core_init (core_init),
    .core_pc   (core_pc),
    .core_done (core_done),
    .busy      (busy),
    .ack       (ack),
    .prog_id   (prog_id),
    .cyc_count (cyc_count),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (core_init) n_init++;
    if (ack)       n_ack++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive req for one cycle; returns in the cycle core_init should be high
  task automatic start(input logic [1:0] sel);
    prog_sel = sel;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("init_not_early", core_init, 0);
    chk("busy_after_req", busy, 1);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(2);
    chk("rst_init", core_init, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_pc", core_pc, 0);
    chk("rst_cyc", cyc_count, 0);
    chk("rst_tmo", timeout, 0);
    reset_n = 1'b1;
    tick(2);

    // Single program 2, done 20 cycles after init
    start(2'd1);
    chk("t1_init", core_init, 1);
    chk("t1_pc", core_pc, 64);
    tick(20); core_done = 1'b1;
    tick();   core_done = 1'b0;
    tick();
    chk("t1_ack_early", ack, 0);
    tick();
    chk("t1_ack", ack, 1);
    chk("t1_busy_ack", busy, 1);
    chk("t1_cyc", cyc_count, 20);
    chk("t1_id", prog_id, 1);
    chk("t1_tmo", timeout, 0);
    tick();
    chk("t1_ack_1cyc", ack, 0);
    chk("t1_busy_low", busy, 0);
    tick(2);

    // Run all: 10/15/12 cycles
    b_init = n_init; b_ack = n_ack;
    start(2'd3);
    chk("t2_pc0", core_pc, 0);
    chk("t2_id0", prog_id, 0);
    tick(10); core_done = 1'b1;
    tick();   core_done = 1'b0;
    tick(2);
    chk("t2_init1", core_init, 1);
    chk("t2_pc1", core_pc, 64);
    chk("t2_cyc1", cyc_count, 10);
    tick(15); core_done = 1'b1;
    tick();   core_done = 1'b0;
    tick(2);
    chk("t2_init2", core_init, 1);
    chk("t2_pc2", core_pc, 128);
    tick(12); core_done = 1'b1;
    tick();   core_done = 1'b0;
    tick(2);
    chk("t2_ack", ack, 1);
    chk("t2_id", prog_id, 2);
    chk("t2_cyc", cyc_count, 12);
    tick(2);
    chk("t2_n_init", n_init - b_init, 3);
    chk("t2_n_ack", n_ack - b_ack, 1);

    // Timeout with run-all, core never finishes
    b_init = n_init; b_ack = n_ack;
    start(2'd3);
    chk("t3_init", core_init, 1);
    tick(101);
    chk("t3_ack_early", ack, 0);
    tick();
    chk("t3_ack", ack, 1);
    chk("t3_tmo", timeout, 1);
    chk("t3_cyc", cyc_count, 100);
    chk("t3_id", prog_id, 0);
    tick();
    chk("t3_busy_low", busy, 0);
    tick(3);
    chk("t3_tmo_sticky", timeout, 1);
    chk("t3_n_init", n_init - b_init, 1);
    chk("t3_n_ack", n_ack - b_ack, 1);

    // Held done level ignored; req during RUN ignored
    b_init = n_init;
    core_done = 1'b1;
    tick(2);
    prog_sel = 2'd0;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("t4_tmo_clr", timeout, 0);
    tick();
    chk("t4_init", core_init, 1);
    tick(2);
    prog_sel = 2'd2; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    core_done = 1'b0;
    tick(5); core_done = 1'b1;
    tick();  core_done = 1'b0;
    tick();
    chk("t4_ack_early", ack, 0);
    tick();
    chk("t4_ack", ack, 1);
    chk("t4_cyc", cyc_count, 9);
    chk("t4_id", prog_id, 0);
    tick(4);
    chk("t4_n_init", n_init - b_init, 1);

    // Reset mid-run
    b_ack = n_ack;
    start(2'd2);
    chk("t5_pc", core_pc, 128);
    tick(30);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_pc", core_pc, 0);
    chk("t5_rst_id", prog_id, 0);
    chk("t5_rst_cyc", cyc_count, 0);
    tick(3);
    reset_n = 1'b1;
    tick(3);
    chk("t5_no_ack", n_ack - b_ack, 0);
    start(2'd0);
    chk("t5_init", core_init, 1);
    chk("t5_pc0", core_pc, 0);
    tick(7); core_done = 1'b1;
    tick();  core_done = 1'b0;
    tick(2);
    chk("t5_ack", ack, 1);
    chk("t5_cyc", cyc_count, 7);
    tick(2);

    // Completion on the same cycle the counter hits TIMEOUT
    start(2'd1);
    chk("t6_init", core_init, 1);
    tick(100); core_done = 1'b1;
    tick();    core_done = 1'b0;
    tick();
    chk("t6_ack_early", ack, 0);
    tick();
    chk("t6_ack", ack, 1);
    chk("t6_tmo", timeout, 0);
    chk("t6_cyc", cyc_count, 100);
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
